// File: rtl/apb_cfg_regfile.sv
// Configuration register file for the DFE filter array, loaded through an
// IDLE/SETUP/ACCESS transaction sequencer; all fields drive the filters continuously.
module apb_cfg_regfile #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned PDATA_WIDTH = 32,
  parameter int unsigned COEFF_WIDTH = 20,
  parameter int unsigned N_TAP       = 72,
  parameter int unsigned NUM_DENUM   = 5,
  parameter int unsigned COMP        = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          MTRANS,
  input  logic                          MWRITE,
  input  logic [COMP-1:0]               MSELx,
  input  logic [ADDR_WIDTH-1:0]         MADDR,
  input  logic signed [COEFF_WIDTH-1:0] MWDATA,
  output logic [PDATA_WIDTH-1:0]        MRDATA,
  output logic                          FRAC_DECI_VLD,
  output logic signed [COEFF_WIDTH-1:0] FRAC_DECI_OUT [N_TAP],
  output logic                          IIR_24_VLD,
  output logic                          IIR_5_1_VLD,
  output logic                          IIR_5_2_VLD,
  output logic signed [COEFF_WIDTH-1:0] IIR_24_OUT [NUM_DENUM],
  output logic signed [COEFF_WIDTH-1:0] IIR_5_1_OUT [NUM_DENUM],
  output logic signed [COEFF_WIDTH-1:0] IIR_5_2_OUT [NUM_DENUM],
  output logic [4:0]                    CTRL,
  output logic [4:0]                    CIC_R_OUT,
  output logic [1:0]                    OUT_SEL,
  output logic [2:0]                    COEFF_SEL,
  output logic [2:0]                    STATUS
);

  localparam int unsigned N_CTRL        = 5;
  localparam int unsigned IIR24_BASE    = N_TAP;
  localparam int unsigned IIR51_BASE    = IIR24_BASE + NUM_DENUM;
  localparam int unsigned IIR52_BASE    = IIR51_BASE + NUM_DENUM;
  localparam int unsigned CIC_ADDR      = IIR52_BASE + NUM_DENUM;
  localparam int unsigned CTRL_BASE     = CIC_ADDR + 1;
  localparam int unsigned OUTSEL_ADDR   = CTRL_BASE + N_CTRL;
  localparam int unsigned COEFFSEL_ADDR = OUTSEL_ADDR + 1;
  localparam int unsigned STATUS_ADDR   = COEFFSEL_ADDR + 1;
  localparam int unsigned FRAC_IW       = $clog2(N_TAP);
  localparam int unsigned IIR_IW        = $clog2(NUM_DENUM);
  localparam int unsigned CTRL_IW       = $clog2(N_CTRL);

  localparam logic [COMP-1:0] SEL_FRAC = COMP'(1);
  localparam logic [COMP-1:0] SEL_IIR  = COMP'(2);
  localparam logic [COMP-1:0] SEL_CIC  = COMP'(4);
  localparam logic [COMP-1:0] SEL_CFG  = COMP'(8);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t                         state, state_nxt;
  logic                           mtrans_d;
  logic                           req_write;
  logic [ADDR_WIDTH-1:0]          req_addr;
  logic [COMP-1:0]                req_sel;
  logic signed [COEFF_WIDTH-1:0]  req_wdata;

  logic                           start_c, access_c;
  logic [31:0]                    addr_c;
  logic                           in_frac_c, in_iir24_c, in_iir51_c, in_iir52_c;
  logic                           in_cic_c, in_ctrl_c, in_outsel_c, in_coeffsel_c, in_status_c;
  logic                           legal_c, wr_c, rd_c;
  logic [FRAC_IW-1:0]             frac_idx_c;
  logic [IIR_IW-1:0]              iir24_idx_c, iir51_idx_c, iir52_idx_c;
  logic [CTRL_IW-1:0]             ctrl_idx_c;
  logic [PDATA_WIDTH-1:0]         rdata_c;

  function automatic logic [PDATA_WIDTH-1:0] sext(input logic signed [COEFF_WIDTH-1:0] v);
    return {{(PDATA_WIDTH - COEFF_WIDTH){v[COEFF_WIDTH-1]}}, v};
  endfunction

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Only a fresh MTRANS rising edge seen in IDLE opens a transaction
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    access_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (MTRANS && !mtrans_d) begin
          start_c   = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: begin
        access_c  = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Address decode and region/select legality of the latched request
  always_comb begin
    addr_c        = 32'(req_addr);
    in_frac_c     = addr_c < IIR24_BASE;
    in_iir24_c    = (addr_c >= IIR24_BASE) && (addr_c < IIR51_BASE);
    in_iir51_c    = (addr_c >= IIR51_BASE) && (addr_c < IIR52_BASE);
    in_iir52_c    = (addr_c >= IIR52_BASE) && (addr_c < CIC_ADDR);
    in_cic_c      = addr_c == CIC_ADDR;
    in_ctrl_c     = (addr_c >= CTRL_BASE) && (addr_c < OUTSEL_ADDR);
    in_outsel_c   = addr_c == OUTSEL_ADDR;
    in_coeffsel_c = addr_c == COEFFSEL_ADDR;
    in_status_c   = addr_c == STATUS_ADDR;
    legal_c = (in_frac_c && (req_sel == SEL_FRAC))
           || ((in_iir24_c || in_iir51_c || in_iir52_c) && (req_sel == SEL_IIR))
           || (in_cic_c && (req_sel == SEL_CIC))
           || ((in_ctrl_c || in_outsel_c || in_coeffsel_c || in_status_c) && (req_sel == SEL_CFG));
    wr_c        = access_c && req_write && legal_c;
    rd_c        = access_c && !req_write;
    frac_idx_c  = FRAC_IW'(addr_c);
    iir24_idx_c = IIR_IW'(addr_c - IIR24_BASE);
    iir51_idx_c = IIR_IW'(addr_c - IIR51_BASE);
    iir52_idx_c = IIR_IW'(addr_c - IIR52_BASE);
    ctrl_idx_c  = CTRL_IW'(addr_c - CTRL_BASE);
  end

  // Read mux: coefficients sign-extended, control fields zero-extended, illegal reads 0
  always_comb begin
    rdata_c = '0;
    if (legal_c) begin
      if (in_frac_c)          rdata_c = sext(FRAC_DECI_OUT[frac_idx_c]);
      else if (in_iir24_c)    rdata_c = sext(IIR_24_OUT[iir24_idx_c]);
      else if (in_iir51_c)    rdata_c = sext(IIR_5_1_OUT[iir51_idx_c]);
      else if (in_iir52_c)    rdata_c = sext(IIR_5_2_OUT[iir52_idx_c]);
      else if (in_cic_c)      rdata_c = PDATA_WIDTH'(CIC_R_OUT);
      else if (in_ctrl_c)     rdata_c = PDATA_WIDTH'(CTRL[ctrl_idx_c]);
      else if (in_outsel_c)   rdata_c = PDATA_WIDTH'(OUT_SEL);
      else if (in_coeffsel_c) rdata_c = PDATA_WIDTH'(COEFF_SEL);
      else if (in_status_c)   rdata_c = PDATA_WIDTH'(STATUS);
    end
  end

  // Request latch, register file, read data and completion pulses
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mtrans_d      <= 1'b0;
      req_write     <= 1'b0;
      req_addr      <= '0;
      req_sel       <= '0;
      req_wdata     <= '0;
      MRDATA        <= '0;
      FRAC_DECI_VLD <= 1'b0;
      IIR_24_VLD    <= 1'b0;
      IIR_5_1_VLD   <= 1'b0;
      IIR_5_2_VLD   <= 1'b0;
      CTRL          <= '0;
      CIC_R_OUT     <= '0;
      OUT_SEL       <= '0;
      COEFF_SEL     <= '0;
      STATUS        <= '0;
      for (int i = 0; i < int'(N_TAP); i++) FRAC_DECI_OUT[i] <= '0;
      for (int i = 0; i < int'(NUM_DENUM); i++) begin
        IIR_24_OUT[i]  <= '0;
        IIR_5_1_OUT[i] <= '0;
        IIR_5_2_OUT[i] <= '0;
      end
    end else begin
      mtrans_d      <= MTRANS;
      FRAC_DECI_VLD <= 1'b0;
      IIR_24_VLD    <= 1'b0;
      IIR_5_1_VLD   <= 1'b0;
      IIR_5_2_VLD   <= 1'b0;
      if (start_c) begin
        req_write <= MWRITE;
        req_addr  <= MADDR;
        req_sel   <= MSELx;
        req_wdata <= MWDATA;
      end
      if (wr_c) begin
        if (in_frac_c)     FRAC_DECI_OUT[frac_idx_c] <= req_wdata;
        if (in_iir24_c)    IIR_24_OUT[iir24_idx_c]   <= req_wdata;
        if (in_iir51_c)    IIR_5_1_OUT[iir51_idx_c]  <= req_wdata;
        if (in_iir52_c)    IIR_5_2_OUT[iir52_idx_c]  <= req_wdata;
        if (in_cic_c)      CIC_R_OUT                 <= req_wdata[4:0];
        if (in_ctrl_c)     CTRL[ctrl_idx_c]          <= req_wdata[0];
        if (in_outsel_c)   OUT_SEL                   <= req_wdata[1:0];
        if (in_coeffsel_c) COEFF_SEL                 <= req_wdata[2:0];
        if (in_status_c)   STATUS                    <= req_wdata[2:0];
        FRAC_DECI_VLD <= addr_c == (IIR24_BASE - 1);
        IIR_24_VLD    <= addr_c == (IIR51_BASE - 1);
        IIR_5_1_VLD   <= addr_c == (IIR52_BASE - 1);
        IIR_5_2_VLD   <= addr_c == (CIC_ADDR - 1);
      end
      if (rd_c) MRDATA <= rdata_c;
    end
  end

endmodule

// File: tb/tb_apb_cfg_regfile.sv
// Directed bench for apb_cfg_regfile: stimulus pushes timed expectations into a
// scoreboard queue, a negedge monitor pops and compares them against the DUT.
module tb_apb_cfg_regfile;

  localparam int unsigned AW = 7;
  localparam int unsigned PW = 32;
  localparam int unsigned CW = 20;
  localparam int unsigned NT = 72;
  localparam int unsigned ND = 5;
  localparam int unsigned NC = 4;

  localparam int K_FRAC = 0, K_I24 = 1, K_I51 = 2, K_I52 = 3, K_CIC = 4, K_CTRL = 5;
  localparam int K_OSEL = 6, K_CSEL = 7, K_STAT = 8, K_RD = 9, K_VLD = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 mtrans, mwrite;
  logic [NC-1:0]        msel;
  logic [AW-1:0]        maddr;
  logic signed [CW-1:0] mwdata;
  logic [PW-1:0]        rdata;
  logic                 vf, v24, v51, v52;
  logic signed [CW-1:0] frac [NT];
  logic signed [CW-1:0] i24 [ND];
  logic signed [CW-1:0] i51 [ND];
  logic signed [CW-1:0] i52 [ND];
  logic [4:0]           ctrl, cic;
  logic [1:0]           osel;
  logic [2:0]           csel, stat;

  apb_cfg_regfile dut (
    .clk(clk), .rst_n(rst_n), .MTRANS(mtrans), .MWRITE(mwrite), .MSELx(msel),
    .MADDR(maddr), .MWDATA(mwdata), .MRDATA(rdata),
    .FRAC_DECI_VLD(vf), .FRAC_DECI_OUT(frac),
    .IIR_24_VLD(v24), .IIR_5_1_VLD(v51), .IIR_5_2_VLD(v52),
    .IIR_24_OUT(i24), .IIR_5_1_OUT(i51), .IIR_5_2_OUT(i52),
    .CTRL(ctrl), .CIC_R_OUT(cic), .OUT_SEL(osel), .COEFF_SEL(csel), .STATUS(stat)
  );

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sx(input logic [CW-1:0] v);
    return {{(32 - CW){v[CW-1]}}, v};
  endfunction

  function automatic logic [31:0] probe(input int kind, input int idx);
    case (kind)
      K_FRAC:  return sx(frac[idx]);
      K_I24:   return sx(i24[idx]);
      K_I51:   return sx(i51[idx]);
      K_I52:   return sx(i52[idx]);
      K_CIC:   return 32'(cic);
      K_CTRL:  return 32'(ctrl[idx]);
      K_OSEL:  return 32'(osel);
      K_CSEL:  return 32'(csel);
      K_STAT:  return 32'(stat);
      K_RD:    return rdata;
      K_VLD:   return {28'd0, v52, v51, v24, vf};
      default: return 32'd0;
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_FRAC:  return "frac";
      K_I24:   return "iir24";
      K_I51:   return "iir5_1";
      K_I52:   return "iir5_2";
      K_CIC:   return "cic_r";
      K_CTRL:  return "ctrl";
      K_OSEL:  return "out_sel";
      K_CSEL:  return "coeff_sel";
      K_STAT:  return "status";
      K_RD:    return "mrdata";
      K_VLD:   return "vld{52,51,24,frac}";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: compare every expectation that falls due on this cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = probe(e.kind, e.idx);
      n_vec++;
      if (act !== e.val || e.cyc != cyc) begin
        n_err++;
        $display("FAIL %s[%0d] due cyc %0d at cyc %0d: got %h expected %h",
                 kname(e.kind), e.idx, e.cyc, cyc, act, e.val);
      end
    end
  end

  // Keep the queue ordered by due cycle
  task automatic push(input int due, input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    int   pos;
    e.cyc = due; e.kind = kind; e.idx = idx; e.val = val;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > due) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  // Present a request at a negedge; c is the cycle count before its sample edge
  task automatic launch(input logic wr, input int addr, input logic [NC-1:0] sel,
                        input logic [CW-1:0] data, output int c);
    @(negedge clk);
    mtrans = 1'b1; mwrite = wr; maddr = AW'(addr); msel = sel; mwdata = data;
    c = cyc;
  endtask

  // Drop MTRANS and scramble the bus so the in-flight transaction must use latched values
  task automatic finish_txn();
    @(negedge clk);
    mtrans = 1'b0; mwrite = ~mwrite; maddr = maddr + AW'(1); msel = ~msel; mwdata = ~mwdata;
    @(negedge clk);
  endtask

  task automatic wr_chk(input int addr, input logic [NC-1:0] sel, input logic [CW-1:0] data,
                        input int kind, input int idx, input logic [31:0] prev,
                        input logic [31:0] expv, input logic [3:0] vld);
    int c;
    launch(1'b1, addr, sel, data, c);
    push(c + 2, kind, idx, prev);
    push(c + 3, kind, idx, expv);
    push(c + 3, K_VLD, 0, 32'(vld));
    push(c + 4, K_VLD, 0, 32'd0);
    finish_txn();
  endtask

  task automatic rd_chk(input int addr, input logic [NC-1:0] sel,
                        input logic [31:0] prev, input logic [31:0] expv);
    int c;
    launch(1'b0, addr, sel, 20'h0, c);
    push(c + 2, K_RD, 0, prev);
    push(c + 3, K_RD, 0, expv);
    finish_txn();
  endtask

  initial begin
    int c;
    rst_n = 1'b1; mtrans = 1'b0; mwrite = 1'b0; msel = '0; maddr = '0; mwdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    push(cyc + 1, K_RD, 0, 32'd0);
    push(cyc + 1, K_FRAC, 0, 32'd0);
    push(cyc + 1, K_FRAC, 71, 32'd0);
    push(cyc + 1, K_I52, 4, 32'd0);
    push(cyc + 1, K_CTRL, 2, 32'd0);
    push(cyc + 1, K_CIC, 0, 32'd0);
    push(cyc + 1, K_STAT, 0, 32'd0);
    push(cyc + 1, K_VLD, 0, 32'd0);

    // Coefficient writes, sign-extended readback, and set-complete pulses
    wr_chk(5,  4'b0001, 20'hFFFFD, K_FRAC, 5,  32'd0, 32'hFFFFFFFD, 4'b0000);
    rd_chk(5,  4'b0001, 32'd0, 32'hFFFFFFFD);
    wr_chk(71, 4'b0001, 20'h12345, K_FRAC, 71, 32'd0, 32'h00012345, 4'b0001);
    wr_chk(72, 4'b0010, 20'h00ABC, K_I24, 0, 32'd0, 32'h00000ABC, 4'b0000);
    wr_chk(76, 4'b0010, 20'h80000, K_I24, 4, 32'd0, 32'hFFF80000, 4'b0010);
    wr_chk(81, 4'b0010, 20'hFFFFF, K_I51, 4, 32'd0, 32'hFFFFFFFF, 4'b0100);
    wr_chk(86, 4'b0010, 20'h7FFFF, K_I52, 4, 32'd0, 32'h0007FFFF, 4'b1000);

    // Control fields take only their low bits
    wr_chk(87, 4'b0100, 20'hFFFF7, K_CIC, 0, 32'd0, 32'h17, 4'b0000);
    for (int i = 0; i < 5; i++)
      wr_chk(88 + i, 4'b1000, 20'hFFFF1, K_CTRL, i, 32'd0, 32'd1, 4'b0000);
    wr_chk(93, 4'b1000, 20'h00007, K_OSEL, 0, 32'd0, 32'd3, 4'b0000);
    wr_chk(94, 4'b1000, 20'h00007, K_CSEL, 0, 32'd0, 32'd7, 4'b0000);
    wr_chk(95, 4'b1000, 20'h00007, K_STAT, 0, 32'd0, 32'd7, 4'b0000);

    // Readback: zero-extended control fields, sign-extended coefficients
    rd_chk(87, 4'b0100, 32'hFFFFFFFD, 32'h00000017);
    rd_chk(81, 4'b0010, 32'h00000017, 32'hFFFFFFFF);
    rd_chk(72, 4'b0010, 32'hFFFFFFFF, 32'h00000ABC);
    rd_chk(93, 4'b1000, 32'h00000ABC, 32'h00000003);
    rd_chk(90, 4'b1000, 32'h00000003, 32'h00000001);

    // Illegal accesses: out of map or mismatched select
    rd_chk(100, 4'b1000, 32'h00000001, 32'd0);
    rd_chk(94,  4'b1000, 32'd0, 32'h00000007);
    rd_chk(5,   4'b0010, 32'h00000007, 32'd0);
    wr_chk(10, 4'b0010, 20'h55555, K_FRAC, 10, 32'd0, 32'd0, 4'b0000);
    wr_chk(72, 4'b0001, 20'h11111, K_I24, 0, 32'h00000ABC, 32'h00000ABC, 4'b0000);
    wr_chk(95, 4'b0100, 20'h00000, K_STAT, 0, 32'd7, 32'd7, 4'b0000);
    wr_chk(71, 4'b0010, 20'h00000, K_FRAC, 71, 32'h00012345, 32'h00012345, 4'b0000);

    // MTRANS held for six cycles with data changing after the latch: one write only
    launch(1'b1, 20, 4'b0001, 20'h00111, c);
    push(c + 3, K_FRAC, 20, 32'h00000111);
    push(c + 7, K_FRAC, 20, 32'h00000111);
    @(negedge clk);
    mwdata = 20'h00222;
    repeat (5) @(negedge clk);
    mtrans = 1'b0;
    @(negedge clk);

    // A rising edge arriving in ACCESS is dropped
    launch(1'b1, 30, 4'b0001, 20'h0AAAA, c);
    push(c + 3, K_FRAC, 30, 32'h0000AAAA);
    push(c + 6, K_FRAC, 31, 32'd0);
    @(negedge clk);
    mtrans = 1'b0;
    @(negedge clk);
    mtrans = 1'b1; maddr = AW'(31); mwdata = 20'h0BBBB;
    @(negedge clk);
    mtrans = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during SETUP aborts the write and clears the file
    rd_chk(93, 4'b1000, 32'd0, 32'd3);
    launch(1'b1, 40, 4'b0001, 20'h00099, c);
    push(c + 3, K_FRAC, 40, 32'd0);
    push(c + 3, K_FRAC, 5, 32'd0);
    push(c + 3, K_RD, 0, 32'd0);
    push(c + 3, K_CIC, 0, 32'd0);
    push(c + 5, K_FRAC, 40, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mtrans = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    wr_chk(40, 4'b0001, 20'h00099, K_FRAC, 40, 32'd0, 32'h00000099, 4'b0000);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);

    // Final state: only the post-reset write to 40 survives
    n_vec++;
    if (frac[40] !== 20'h00099) begin
      n_err++;
      $display("FAIL final frac[40]: got %h expected 00099", frac[40]);
    end
    n_vec++;
    if (frac[71] !== 20'h00000) begin
      n_err++;
      $display("FAIL final frac[71]: got %h expected 00000", frac[71]);
    end
    n_vec++;
    if (ctrl !== 5'd0 || cic !== 5'd0) begin
      n_err++;
      $display("FAIL final ctrl/cic: got %h/%h expected 00/00", ctrl, cic);
    end
    n_vec++;
    if (stat !== 3'd0 || osel !== 2'd0) begin
      n_err++;
      $display("FAIL final status/out_sel: got %h/%h expected 0/0", stat, osel);
    end
    n_vec++;
    if (rdata !== 32'd0) begin
      n_err++;
      $display("FAIL final mrdata: got %h expected 0", rdata);
    end
    n_vec++;
    if ({v52, v51, v24, vf} !== 4'b0000) begin
      n_err++;
      $display("FAIL final vld: got %b expected 0000", {v52, v51, v24, vf});
    end

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s[%0d] never checked (due cyc %0d) expected %h", kname(e.kind), e.idx, e.cyc, e.val);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
